spi_sclk_edge_detector_n: RTL and testbench



---
 rtl/spi_sclk_edge_detector_n_if.sv | 13 +
 rtl/spi_sclk_edge_detector_n.sv | 64 ++++++
 tb/tb_spi_sclk_edge_detector_n.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/spi_sclk_edge_detector_n_if.sv
// spi_sclk_edge_detector_n_if: sampling controls, raw input lines and per-channel filtered edge outputs
interface spi_sclk_edge_detector_n_if #(parameter int CH = 1);
  logic en;
  logic [1:0] mode;
  logic [CH-1:0] din;
  logic tick;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] dout;
  modport master(output en, mode, din, input tick, level, rise, fall, dout);
  modport slave(input en, mode, din, output tick, level, rise, fall, dout);
endinterface

// File: rtl/spi_sclk_edge_detector_n.sv
// spi_sclk_edge_detector_n: divided-tick sampler with synchroniser, glitch filter and per-channel edge pulses
module spi_sclk_edge_detector_n #(
  parameter int CH = 1,
  parameter int DIV = 32,
  parameter int TICK_PHASE = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT = 1
) (
  input logic clk,
  input logic n_rst,
  spi_sclk_edge_detector_n_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam int FW = $clog2(FILT + 1);
  logic [CW-1:0] cnt;
  logic tick;
  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] sq;
  logic [FW-1:0] fcnt [CH];
  logic [CH-1:0] diff;
  logic [CH-1:0] accept;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] dout;
  assign tick = bus.en && cnt == CW'(TICK_PHASE);
  assign sq = sync_q[SYNC_STAGES-1];
  assign diff = sq ^ level;
  assign bus.tick = tick;
  assign bus.level = level;
  assign bus.rise = rise;
  assign bus.fall = fall;
  assign bus.dout = dout;
  // free-running sample divider, parked at zero while disabled so re-enable starts a fresh period
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else cnt <= !bus.en ? '0 : (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
  // synchroniser chain for the asynchronous lines, clocked every cycle independent of en
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= bus.din;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  // a change is accepted on the tick that completes FILT consecutive differing samples
  always_comb
    for (int c = 0; c < CH; c++) accept[c] = tick && diff[c] && fcnt[c] == FW'(FILT - 1);
  // filter counters advance only on ticks; level and the one-cycle pulses follow accepted changes
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      for (int c = 0; c < CH; c++) fcnt[c] <= '0;
      level <= '0;
      rise <= '0;
      fall <= '0;
      dout <= '0;
    end else begin
      for (int c = 0; c < CH; c++) fcnt[c] <= !tick ? fcnt[c] : (!diff[c] || accept[c]) ? '0 : fcnt[c] + 1'b1;
      level <= level ^ accept;
      rise <= accept & sq;
      fall <= accept & ~sq;
      dout <= (accept & sq & {CH{bus.mode[0]}}) | (accept & ~sq & {CH{bus.mode[1]}});
    end
endmodule

// File: tb/tb_spi_sclk_edge_detector_n.sv
// tb_spi_sclk_edge_detector_n: directed checks of a default single-channel and a filtered four-channel detector
module tb_spi_sclk_edge_detector_n;
  logic clk;
  logic n_rst;
  int errors = 0;
  int checks = 0;
  int p;
  spi_sclk_edge_detector_n_if #(.CH(1)) ai();
  spi_sclk_edge_detector_n_if #(.CH(4)) bi();
  spi_sclk_edge_detector_n #(.CH(1)) ua(.clk(clk), .n_rst(n_rst), .bus(ai.slave));
  spi_sclk_edge_detector_n #(.CH(4), .DIV(4), .FILT(3)) ub(.clk(clk), .n_rst(n_rst), .bus(bi.slave));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic run_b(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      pulses += $countones(bi.rise | bi.fall);
    end
  endtask
  initial begin
    n_rst = 0;
    ai.en = 1; ai.din = 1; ai.mode = 2'b01;
    bi.en = 0; bi.din = 0; bi.mode = 2'b11;
    step(2);
    n_rst = 1;
    step(40);
    chk("pre_rst_level", ai.level, 1);
    @(negedge clk);
    #2 n_rst = 0;
    #1;
    chk("rst_level", ai.level, 0);
    chk("rst_tick", ai.tick, 0);
    chk("rst_pulses", {ai.rise, ai.fall, ai.dout}, 0);
    @(negedge clk);
    n_rst = 1;
    step(1);
    chk("first_tick", ai.tick, 1);
    step(1);
    chk("tick_low", ai.tick, 0);
    chk("sync_not_yet", ai.rise, 0);
    step(31);
    chk("second_tick", ai.tick, 1);
    chk("pre_rise", ai.level, 0);
    step(1);
    chk("rst_rise", {ai.rise, ai.fall, ai.dout, ai.level}, 4'b1011);
    step(1);
    chk("rise_1clk", {ai.rise, ai.dout, ai.level}, 3'b001);
    ai.din = 0;
    step(30);
    chk("pre_fall", {ai.fall, ai.level}, 2'b01);
    step(1);
    chk("fall_pulse", {ai.rise, ai.fall, ai.dout, ai.level}, 4'b0100);
    step(1);
    chk("fall_1clk", ai.fall, 0);
    step(9);
    ai.din = 1;
    step(21);
    chk("rise22_early", {ai.rise, ai.level}, 0);
    step(1);
    chk("rise22", {ai.rise, ai.fall, ai.dout, ai.level}, 4'b1011);
    step(1);
    chk("rise22_1clk", {ai.rise, ai.dout}, 0);
    ai.mode = 2'b10;
    ai.din = 0;
    step(31);
    chk("m10_fall", {ai.rise, ai.fall, ai.dout}, 3'b011);
    step(1);
    ai.din = 1;
    step(31);
    chk("m10_rise", {ai.rise, ai.fall, ai.dout}, 3'b100);
    step(1);
    ai.mode = 2'b00;
    ai.din = 0;
    step(31);
    chk("m00_fall", {ai.rise, ai.fall, ai.dout}, 3'b010);
    step(1);
    ai.din = 1;
    step(31);
    chk("m00_rise", {ai.rise, ai.fall, ai.dout}, 3'b100);
    step(1);
    ai.en = 0;
    #1;
    chk("gate_tick", ai.tick, 0);
    p = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ai.din = ~ai.din;
      p += int'(ai.tick) + int'(ai.rise) + int'(ai.fall) + int'(ai.dout);
    end
    chk("gate_quiet", p, 0);
    ai.din = 0;
    step(3);
    chk("gate_level", {ai.level, ai.tick}, 2'b10);
    ai.en = 1;
    step(1);
    chk("reen_tick", {ai.tick, ai.level}, 2'b11);
    step(1);
    chk("reen_fall", {ai.fall, ai.level}, 2'b10);
    bi.en = 1;
    bi.din = 4'b0001;
    run_b(11, p);
    bi.din = 4'b0000;
    run_b(10, p);
    chk("glitch_pulses", p, 0);
    chk("glitch_level", bi.level, 0);
    bi.din = 4'b0001;
    run_b(12, p);
    chk("filt_early", {p[3:0], bi.level}, 0);
    step(1);
    chk("filt_rise", {bi.rise, bi.fall, bi.dout, bi.level}, 16'h1011);
    step(1);
    chk("filt_1clk", {bi.rise, bi.dout}, 0);
    bi.din = 4'b0101;
    step(15);
    chk("mc_setup", bi.level, 4'b0101);
    bi.din = 4'b1010;
    run_b(11, p);
    chk("mc_early", {p[3:0], bi.level}, 8'h05);
    step(1);
    chk("mc_rise", bi.rise, 4'b1010);
    chk("mc_fall", bi.fall, 4'b0101);
    chk("mc_dout", bi.dout, 4'b1111);
    chk("mc_level", bi.level, 4'b1010);
    step(1);
    chk("mc_1clk", {bi.rise, bi.fall, bi.dout}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
